// File: rtl/pop_counter_bank.sv
// Per-channel pop counters for the four output FIFOs,
// with a one-cycle readout port gated by the transaction-layer IDLE state.
module pop_counter_bank #(
    parameter int CW  = 5,
    parameter int NCH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          idle,
    input  logic          pop_in0,
    input  logic          pop_in1,
    input  logic          pop_in2,
    input  logic          pop_in3,
    input  logic          empty4,
    input  logic          empty5,
    input  logic          empty6,
    input  logic          empty7,
    input  logic          req,
    input  logic [1:0]    idx,
    output logic [CW-1:0] contador,
    output logic          valid
);

    typedef enum logic {
        WAIT  = 1'b0,
        SERVE = 1'b1
    } rd_state_e;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [NCH-1:0] pop;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] hit;

    logic [CW-1:0]  cnt_q [NCH];

    rd_state_e      state_q;
    rd_state_e      state_d;
    logic           req_q;
    logic           req_d;
    logic [CW-1:0]  data_q;
    logic [CW-1:0]  data_d;

    assign pop   = {pop_in3, pop_in2, pop_in1, pop_in0};
    assign empty = {empty7, empty6, empty5, empty4};
    assign hit   = pop & ~empty;

    // Counters are independent of the readout path; they saturate.
    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else if (hit[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    // Snapshot is taken from pre-increment counter values.
    always_comb begin
        state_d = WAIT;
        req_d   = 1'b0;
        data_d  = '0;
        unique case (1'b1)
            idle: begin
                state_d = SERVE;
                req_d   = req;
                if (req) begin
                    data_d = cnt_q[idx];
                end
            end
            default: begin
                state_d = WAIT;
            end
        endcase
    end

    assign valid    = (state_q == SERVE) && req_q;
    assign contador = data_q;

endmodule

// File: tb/tb_pop_counter_bank.sv
// Directed bench for pop_counter_bank: counting, saturation,
// empty gating, readout latency/gating and reset priority.
module tb_pop_counter_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       idle;
    logic       pop_in0, pop_in1, pop_in2, pop_in3;
    logic       empty4, empty5, empty6, empty7;
    logic       req;
    logic [1:0] idx;
    logic [4:0] contador;
    logic       valid;

    int total  = 0;
    int passed = 0;

    pop_counter_bank #(.CW(5), .NCH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .idle     (idle),
        .pop_in0  (pop_in0),
        .pop_in1  (pop_in1),
        .pop_in2  (pop_in2),
        .pop_in3  (pop_in3),
        .empty4   (empty4),
        .empty5   (empty5),
        .empty6   (empty6),
        .empty7   (empty7),
        .req      (req),
        .idx      (idx),
        .contador (contador),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input int ch, input int exp);
        req = 1'b1;
        idx = 2'(ch);
        tick(1);
        chk({tag, "_valid"}, int'(valid), 1);
        chk({tag, "_data"}, int'(contador), exp);
    endtask

    initial begin
        reset = 1'b1; idle = 1'b0; req = 1'b0; idx = 2'd0;
        pop_in0 = 1'b0; pop_in1 = 1'b0; pop_in2 = 1'b0; pop_in3 = 1'b0;
        empty4 = 1'b0; empty5 = 1'b0; empty6 = 1'b0; empty7 = 1'b0;
        tick(2);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(contador), 0);
        reset = 1'b0;

        // three counted pops on ch0 while idle is low
        pop_in0 = 1'b1;
        tick(3);
        pop_in0 = 1'b0;
        idle = 1'b1;
        rd("ch0_three", 0, 3);
        req = 1'b0;
        tick(1);
        chk("noreq_valid", int'(valid), 0);
        chk("noreq_data", int'(contador), 0);

        // empty-gated pops on ch2
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pop_in2 = 1'b1; empty6 = 1'b1;
        tick(2);
        empty6 = 1'b0;
        tick(5);
        pop_in2 = 1'b0;
        rd("ch2_five", 2, 5);
        rd("ch0_zero", 0, 0);
        rd("ch1_zero", 1, 0);
        rd("ch3_zero", 3, 0);
        req = 1'b0;

        // ch1 saturation, with a read mid-stream returning pre-increment value
        pop_in1 = 1'b1;
        tick(10);
        rd("ch1_preinc", 1, 10);
        req = 1'b0;
        tick(29);
        pop_in1 = 1'b0;
        rd("ch1_sat", 1, 31);
        req = 1'b0;

        // simultaneous pops on ch0 and ch3
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pop_in0 = 1'b1; pop_in3 = 1'b1;
        tick(4);
        pop_in0 = 1'b0; pop_in3 = 1'b0;
        rd("b2b_ch0", 0, 4);
        rd("b2b_ch3", 3, 4);

        // request while not idle is dropped
        idle = 1'b0;
        req = 1'b1; idx = 2'd3;
        tick(1);
        chk("notidle_valid", int'(valid), 0);
        chk("notidle_data", int'(contador), 0);
        idle = 1'b1;
        tick(1);
        chk("idle_up_valid", int'(valid), 1);
        chk("idle_up_data", int'(contador), 4);
        idle = 1'b0;
        tick(1);
        chk("idle_fall_valid", int'(valid), 0);

        // reset beats a serviced request and a counted pop
        idle = 1'b1; req = 1'b1; idx = 2'd0;
        pop_in1 = 1'b1; reset = 1'b1;
        tick(1);
        chk("rst_pri_valid", int'(valid), 0);
        chk("rst_pri_data", int'(contador), 0);
        reset = 1'b0; pop_in1 = 1'b0; req = 1'b0;
        rd("post_rst_ch0", 0, 0);
        rd("post_rst_ch1", 1, 0);
        rd("post_rst_ch3", 3, 0);

        // counting resumes right after reset
        req = 1'b0;
        pop_in2 = 1'b1;
        tick(1);
        pop_in2 = 1'b0;
        rd("resume_ch2", 2, 1);
        req = 1'b0;
        tick(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
